frame_collector: RTL and testbench

FRAME_COLLECTOR -- requirements
Module: frame_collector

---
 rtl/frequency_machine_pkg.sv | 21 ++
 rtl/simple_dp_ram.sv | 28 ++
 rtl/frame_collector.sv | 184 ++++++++++++++++++
 tb/tb_frame_collector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frequency_machine_pkg.sv
// Shared types for the frame collector: ping-pong bank states and read-FSM states.
package frequency_machine_pkg;

    typedef enum logic [1:0] {
        BANK_FREE,
        BANK_FILLING,
        BANK_FULL,
        BANK_READING
    } bank_state_t;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_FETCH,
        RD_STREAM
    } rd_state_t;

    function automatic logic bank_is_free(input bank_state_t s);
        return s == BANK_FREE;
    endfunction

endpackage

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: one write port, one registered (1-cycle) read port.
module simple_dp_ram #(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write on we_i; read data appears one cycle after the address.
    // NOTE: storage has no reset so it maps onto block RAM; non-blocking assignments keep read-before-write ordering.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_collector.sv
// Ping-pong frame collector: fills one bank from sample ticks while the other
// streams out over a valid/ready interface. Optional macro
// FRAME_COLLECTOR_OVERRUN_CNT_EN adds a saturating dropped-sample counter.
module frame_collector
    import frequency_machine_pkg::*;
#(
    parameter int DW        = 16,
    parameter int FRAME_LEN = 256
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] data_i,
    input  logic          sample_tick_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          last_o,
    output logic          overrun_o,
    output logic [15:0]   overrun_cnt_o
);

    localparam int            IW       = $clog2(FRAME_LEN);
    localparam int            AW       = IW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);

    bank_state_t [1:0] bank_q, bank_d;
    logic              wr_bank_q, wr_bank_d;
    logic [IW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              wr_wait_q, wr_wait_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IW-1:0]     rd_idx_q, rd_idx_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;

    logic              wr_en, wr_done, wr_other, fire, rd_free;
    logic [IW-1:0]     rd_idx_inc, rd_addr_idx;
    logic [DW-1:0]     rdata;

    simple_dp_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i ({wr_bank_q, wr_ptr_q}),
        .wdata_i (data_i),
        .raddr_i ({rd_bank_q, rd_addr_idx}),
        .rdata_o (rdata)
    );

    // Next-state logic: reader frees first, writer claims, then an idle reader grabs a full bank.
    always_comb begin
        // NOTE: every _d starts from its _q value so no path leaves a variable unassigned (no latches).
        bank_d      = bank_q;
        wr_bank_d   = wr_bank_q;
        wr_ptr_d    = wr_ptr_q;
        wr_wait_d   = wr_wait_q;
        rd_state_d  = rd_state_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        valid_d     = valid_q;
        last_d      = last_q;
        rd_addr_idx = '0;

        wr_en      = sample_tick_i && !wr_wait_q;
        wr_done    = wr_en && (wr_ptr_q == LAST_IDX);
        wr_other   = ~wr_bank_q;
        fire       = valid_q && ready_i;
        rd_free    = (rd_state_q == RD_STREAM) && fire && last_q;
        rd_idx_inc = rd_idx_q + 1'b1;

        // A bank released by the reader is visible to the writer in the same cycle.
        if (rd_free) begin
            bank_d[rd_bank_q] = BANK_FREE;
        end

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_done) begin
                bank_d[wr_bank_q] = BANK_FULL;
                if (bank_is_free(bank_d[wr_other])) begin
                    bank_d[wr_other] = BANK_FILLING;
                    wr_bank_d        = wr_other;
                end else begin
                    wr_wait_d = 1'b1;
                end
            end
        end else if (wr_wait_q && bank_is_free(bank_d[wr_other])) begin
            bank_d[wr_other] = BANK_FILLING;
            wr_bank_d        = wr_other;
            wr_ptr_d         = '0;
            wr_wait_d        = 1'b0;
        end

        case (rd_state_q)
            RD_IDLE: begin
                // Banks complete alternately, so rd_bank always names the oldest full one.
                if ((bank_q[rd_bank_q] == BANK_FULL) || (wr_done && (wr_bank_q == rd_bank_q))) begin
                    bank_d[rd_bank_q] = BANK_READING;
                    rd_state_d        = RD_FETCH;
                end
            end
            RD_FETCH: begin
                rd_idx_d   = '0;
                valid_d    = 1'b1;
                last_d     = 1'b0;
                rd_state_d = RD_STREAM;
            end
            RD_STREAM: begin
                // Re-read the current word while stalled; advance on a handshake for a bubble-free stream.
                rd_addr_idx = fire ? rd_idx_inc : rd_idx_q;
                if (fire) begin
                    if (last_q) begin
                        valid_d    = 1'b0;
                        last_d     = 1'b0;
                        rd_idx_d   = '0;
                        rd_bank_d  = ~rd_bank_q;
                        rd_state_d = RD_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_inc;
                        last_d   = (rd_idx_inc == LAST_IDX);
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // State registers for bank table, write side and read FSM with its registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bank_q[0]  <= BANK_FILLING;
            bank_q[1]  <= BANK_FREE;
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            wr_wait_q  <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_bank_q  <= 1'b0;
            rd_idx_q   <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_wait_q  <= wr_wait_d;
            rd_state_q <= rd_state_d;
            rd_bank_q  <= rd_bank_d;
            rd_idx_q   <= rd_idx_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    // The RAM output register holds the word while stalled; gate to zero when nothing is offered.
    assign data_o    = valid_q ? rdata : '0;
    assign valid_o   = valid_q;
    assign last_o    = last_q;
    assign overrun_o = sample_tick_i && wr_wait_q;

`ifdef FRAME_COLLECTOR_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt_q, ovr_cnt_d;

    // Saturating count of dropped samples.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_o && (ovr_cnt_q != 16'hFFFF)) begin
            ovr_cnt_d = ovr_cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovr_cnt_q <= 16'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt_o = ovr_cnt_q;
`else
    assign overrun_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_frame_collector.sv
// Self-checking bench for frame_collector (FRAME_LEN=8): frame-level model plus directed scenarios.
module tb_frame_collector;

    localparam int DW = 16;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          tick;
    logic          ready;
    logic [DW-1:0] data_o;
    logic          valid_o, last_o, overrun_o;
    logic [15:0]   overrun_cnt_o;

    int total = 0;
    int bad   = 0;

    // Model state: complete frames awaiting output, current partial frame, bank occupancy.
    int unsigned exp_q[$];
    int unsigned cur_q[$];
    int unsigned hs_log[$];
    int          n_full = 0;
    bit          m_wait = 0;
    int          hs_in_frame = 0;
    bit          prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    int          idle_run = 0;
    int          ovr_seen = 0;
    int          stall_cnt = 0;
    int          sim_hit = 0;
    int          mode = 0;

    frame_collector #(.DW(DW), .FRAME_LEN(FL)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_i        (din),
        .sample_tick_i (tick),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready),
        .last_o        (last_o),
        .overrun_o     (overrun_o),
        .overrun_cnt_o (overrun_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Ready pattern generator: 0=always, 1=toggle, 2=never, 3=mostly, 4=rarely.
    always @(posedge clk) begin
        #1;
        case (mode)
            0: ready = 1'b1;
            1: ready = ~ready;
            2: ready = 1'b0;
            3: ready = ($urandom_range(0, 3) != 0);
            default: ready = ($urandom_range(0, 9) == 0);
        endcase
    end

    // Compare process: checks outputs against the frame-level model, then advances the model.
    always @(negedge clk) begin
        bit hs, free, old_wait;
        int unsigned ev;
        if (rst) begin
            exp_q.delete();
            cur_q.delete();
            n_full      = 0;
            m_wait      = 0;
            hs_in_frame = 0;
            prev_stall  = 0;
            idle_run    = 0;
        end else begin
            check("overrun_pulse", {31'd0, overrun_o}, {31'd0, tick && m_wait});
            if (overrun_o) ovr_seen++;
            if (prev_stall) begin
                stall_cnt++;
                check("hold_valid", {31'd0, valid_o}, 32'd1);
                check("hold_data", {16'd0, data_o}, {16'd0, prev_data});
                check("hold_last", {31'd0, last_o}, {31'd0, prev_last});
            end
            if (valid_o) check("valid_has_frame", {31'd0, n_full > 0}, 32'd1);
            if (!valid_o && n_full > 0) idle_run++;
            else idle_run = 0;
            check("valid_latency", {31'd0, idle_run <= 4}, 32'd1);

            hs   = valid_o && ready;
            free = 0;
            if (hs) begin
                check("hs_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check("stream_data", {16'd0, data_o}, ev);
                end
                check("stream_last", {31'd0, last_o}, {31'd0, hs_in_frame == FL - 1});
                hs_log.push_back(32'(data_o));
                if (hs_in_frame == FL - 1) begin
                    hs_in_frame = 0;
                    free = 1;
                end else begin
                    hs_in_frame++;
                end
            end

            old_wait = m_wait;
            if (free) begin
                n_full--;
                m_wait = 0;
            end
            if (tick && !old_wait) begin
                cur_q.push_back(32'(din));
                if (cur_q.size() == FL) begin
                    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                    cur_q.delete();
                    n_full++;
                    if (free) sim_hit++;
                    if (n_full >= 2) m_wait = 1;
                end
            end

            prev_stall = valid_o && !ready;
            prev_data  = data_o;
            prev_last  = last_o;
        end
    end

    task automatic send(input logic [DW-1:0] v);
        @(posedge clk); #1;
        tick = 1'b1;
        din  = v;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic set_mode(input int m);
        @(negedge clk);
        mode = m;
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            if (n_full == 0 && !valid_o) done = 1;
        end
        check("drain_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, o, s, h;
        bit seen;
        rst = 1'b1; tick = 1'b0; din = '0; ready = 1'b1; mode = 0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_last", {31'd0, last_o}, 32'd0);
        check("rst_overrun", {31'd0, overrun_o}, 32'd0);
        check("rst_cnt", {16'd0, overrun_cnt_o}, 32'd0);
        check("rst_data", {16'd0, data_o}, 32'd0);
        rst = 1'b0;

        // Basic streaming: ticks every 4 cycles, valid exactly 2 cycles after the 8th tick.
        for (int i = 1; i <= FL; i++) begin
            send(DW'(i));
            if (i != FL) repeat (2) @(posedge clk);
        end
        @(negedge clk);
        check("lat_t1_valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        check("lat_t2_valid", {31'd0, valid_o}, 32'd1);
        check("lat_t2_data", {16'd0, data_o}, 32'd1);
        for (int k = 2; k <= FL; k++) begin
            @(negedge clk);
            check("burst_data", {16'd0, data_o}, k);
            check("burst_last", {31'd0, last_o}, {31'd0, k == FL});
        end
        @(negedge clk);
        check("burst_end_valid", {31'd0, valid_o}, 32'd0);

        // Backpressure: toggling ready during the frame.
        set_mode(1);
        b = hs_log.size(); s = stall_cnt;
        for (int i = 0; i < FL; i++) send(DW'(11 + i));
        wait_drain(100);
        check("bp_hs_count", hs_log.size() - b, 8);
        check("bp_first", hs_log[b], 11);
        check("bp_last", hs_log[b + 7], 18);
        check("bp_stalls_seen", {31'd0, stall_cnt > s}, 32'd1);

        // Overrun: three frames while ready is low; the third frame is dropped.
        set_mode(2);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2; rst = 1'b0;
        o = ovr_seen; b = hs_log.size();
        for (int i = 0; i < 3 * FL; i++) send(DW'(101 + i));
        check("ovr_pulses", ovr_seen - o, 8);
`ifdef FRAME_COLLECTOR_OVERRUN_CNT_EN
        check("ovr_cnt", {16'd0, overrun_cnt_o}, 32'd8);
`else
        check("ovr_cnt_tied", {16'd0, overrun_cnt_o}, 32'd0);
`endif
        set_mode(0);
        wait_drain(100);
        check("ovr_hs_count", hs_log.size() - b, 16);
        check("ovr_f1_first", hs_log[b], 101);
        check("ovr_f2_first", hs_log[b + 8], 109);
        check("ovr_f2_last", hs_log[b + 15], 116);

        // Simultaneous free and frame completion.
        set_mode(2);
        o = ovr_seen; b = hs_log.size(); h = sim_hit;
        for (int i = 0; i < FL; i++) send(DW'(401 + i));
        for (int i = 0; i < FL - 1; i++) send(DW'(501 + i));
        @(negedge clk);
        mode = 0;
        repeat (7) @(posedge clk);
        send(DW'(508));
        wait_drain(100);
        check("sim_hit", sim_hit - h, 1);
        check("sim_no_overrun", ovr_seen - o, 0);
        check("sim_hs_count", hs_log.size() - b, 16);
        check("sim_f2_first", hs_log[b + 8], 501);
        check("sim_f2_last", hs_log[b + 15], 508);

        // Reset mid-stream, then a clean frame.
        b = hs_log.size();
        for (int i = 0; i < FL; i++) send(DW'(201 + i));
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk); #1;
            if (hs_log.size() >= b + 4) seen = 1;
        end
        check("mid_reached", {31'd0, seen}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        check("mid_rst_last", {31'd0, last_o}, 32'd0);
        check("mid_rst_data", {16'd0, data_o}, 32'd0);
        check("mid_rst_cnt", {16'd0, overrun_cnt_o}, 32'd0);
        repeat (3) @(posedge clk);
        #2; rst = 1'b0;
        b = hs_log.size(); o = ovr_seen;
        for (int i = 0; i < FL; i++) send(DW'(301 + i));
        wait_drain(100);
        check("post_rst_hs", hs_log.size() - b, 8);
        check("post_rst_first", hs_log[b], 301);
        check("post_rst_last", hs_log[b + 7], 308);
        check("post_rst_no_ovr", ovr_seen - o, 0);

        // Randomized traffic with alternating fast/slow consumers.
        for (int ph = 0; ph < 4; ph++) begin
            set_mode(ph[0] ? 4 : 3);
            repeat (200) begin
                @(posedge clk); #1;
                tick = ($urandom_range(0, 2) == 0);
                din  = DW'($urandom);
            end
        end
        @(posedge clk); #1;
        tick = 1'b0;
        set_mode(0);
        wait_drain(300);
        check("rand_leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
